fetch: RTL and testbench

- Instruction-fetch stage directly upstream of the decode stage.
- Generates the bundle PC and drives a synchronous instruction BRAM with 1-cycle read latency and one 64-bit upper/lower bundle per address.
- Presents a registered `pc` and `inst` pair to decode.
- Obeys decode's `interlock` (hold) and `branch_flag`/`branch_pc` (redirect); wrong-path bundles are squashed to the Nop bundle.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_if.sv | 23 ++
 rtl/fetch_skid.sv | 41 ++++
 rtl/fetch.sv | 132 +++++++++++++
 tb/tb_fetch.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared instruction definitions: opcode set, the Nop bundle and the fetch FSM state type.
package fetch_pkg;

  typedef enum logic [5:0] {
    OP_ADD = 6'h01,
    OP_SUB = 6'h02,
    OP_LD  = 6'h10,
    OP_ST  = 6'h11,
    OP_BR  = 6'h20,
    Nop    = 6'h3F
  } opcode_t;

  localparam logic [63:0] NOP_BUNDLE = {Nop, 26'b0, Nop, 26'b0};

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch bus: decode-side control/result signals plus the instruction BRAM port.
interface fetch_if #(
  parameter int ADDR_W = 15
);
  logic              interlock;
  logic              branch_flag;
  logic [31:0]       branch_pc;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_en;
  logic [63:0]       imem_dout;
  logic [31:0]       pc;
  logic [63:0]       inst;

  modport master (
    input  interlock, branch_flag, branch_pc, imem_dout,
    output imem_addr, imem_en, pc, inst
  );

  modport slave (
    output interlock, branch_flag, branch_pc, imem_dout,
    input  imem_addr, imem_en, pc, inst
  );
endinterface

// File: rtl/fetch_skid.sv
// One-entry pc/inst holding buffer; flush beats load, load beats drain.
module fetch_skid
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_load,
  input  logic        i_drain,
  input  logic        i_flush,
  input  logic [31:0] i_pc,
  input  logic [63:0] i_inst,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [63:0] o_inst
);

  logic        r_valid;
  logic [31:0] r_pc;
  logic [63:0] r_inst;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= 1'b0;
      r_pc    <= 32'h0;
      r_inst  <= NOP_BUNDLE;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_inst  <= i_inst;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_inst  = r_inst;

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: issues bundle addresses to the BRAM and presents pc/inst to decode.
// Defining FETCH_PERF_EN adds saturating perf_fetched/perf_squashed counters.
module fetch
  import fetch_pkg::*;
#(
  parameter int          ADDR_W   = 15,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic    clk,
  input  logic    rstn,
  fetch_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_squashed
`endif
);

  localparam logic [1:0] ST_BOOT = BOOT;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_HOLD = HOLD;

  logic [1:0]  r_state;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_resp_pc;
  logic        r_resp_valid;
  logic [31:0] r_pc;
  logic [63:0] r_inst;

  logic        w_issue;
  logic        w_out_load;
  logic        w_skid_load;
  logic        w_skid_drain;
  logic        w_skid_valid;
  logic [31:0] w_skid_pc;
  logic [63:0] w_skid_inst;
  logic [31:0] w_out_pc;
  logic [63:0] w_out_inst;

  // A redirect cycle never issues: the target is fetched the following cycle.
  assign w_issue = (r_state == ST_RUN) && !bus.interlock && !w_skid_valid && !bus.branch_flag;
  assign w_out_load = !bus.branch_flag && !bus.interlock &&
                      ((r_state == ST_RUN) || (r_state == ST_HOLD));
  assign w_skid_load  = !bus.branch_flag && (r_state == ST_RUN) && bus.interlock && r_resp_valid;
  assign w_skid_drain = w_out_load && w_skid_valid;

  assign bus.imem_addr = r_fetch_pc[ADDR_W-1:0];
  assign bus.imem_en   = w_issue;
  assign bus.pc        = r_pc;
  assign bus.inst      = r_inst;

  fetch_skid u_skid (
    .clk     (clk),
    .rstn    (rstn),
    .i_load  (w_skid_load),
    .i_drain (w_skid_drain),
    .i_flush (bus.branch_flag),
    .i_pc    (r_resp_pc),
    .i_inst  (bus.imem_dout),
    .o_valid (w_skid_valid),
    .o_pc    (w_skid_pc),
    .o_inst  (w_skid_inst)
  );

  // The skid entry is always older than any response in flight.
  always_comb begin
    w_out_pc   = r_pc;
    w_out_inst = NOP_BUNDLE;
    if (w_skid_valid) begin
      w_out_pc   = w_skid_pc;
      w_out_inst = w_skid_inst;
    end else if (r_resp_valid) begin
      w_out_pc   = r_resp_pc;
      w_out_inst = bus.imem_dout;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ST_BOOT;
      r_fetch_pc   <= RESET_PC;
      r_resp_pc    <= 32'h0;
      r_resp_valid <= 1'b0;
      r_pc         <= 32'h0;
      r_inst       <= NOP_BUNDLE;
    end else if (bus.branch_flag) begin
      r_fetch_pc   <= bus.branch_pc;
      r_resp_valid <= 1'b0;
      r_inst       <= NOP_BUNDLE;
      r_state      <= ST_RUN;
    end else begin
      r_resp_valid <= w_issue;
      if (w_issue) begin
        r_resp_pc  <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + 32'd1;
      end
      if (w_out_load) begin
        r_pc   <= w_out_pc;
        r_inst <= w_out_inst;
      end
      case (r_state)
        ST_BOOT: r_state <= ST_RUN;
        ST_RUN:  if (bus.interlock && r_resp_valid) r_state <= ST_HOLD;
        ST_HOLD: if (!bus.interlock) r_state <= ST_RUN;
        default: r_state <= ST_BOOT;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_squashed;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_perf_fetched  <= 32'h0;
      r_perf_squashed <= 32'h0;
    end else begin
      if (!bus.branch_flag && w_out_load && (w_out_inst != NOP_BUNDLE) &&
          (r_perf_fetched != 32'hFFFF_FFFF))
        r_perf_fetched <= r_perf_fetched + 32'd1;
      if (bus.branch_flag && (r_resp_valid || w_skid_valid) &&
          (r_perf_squashed != 32'hFFFF_FFFF))
        r_perf_squashed <= r_perf_squashed + 32'd1;
    end
  end

  assign perf_fetched  = r_perf_fetched;
  assign perf_squashed = r_perf_squashed;
`endif

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: directed timing checks plus a random interlock/redirect run scored against an address-stream model.
module tb_fetch;
  import fetch_pkg::*;

  localparam int ADDR_W = 15;
  localparam logic [63:0] NOPB = {Nop, 26'b0, Nop, 26'b0};

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fetch_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_squashed;
`endif

  fetch #(.ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_squashed (perf_squashed)
`endif
  );

  logic [63:0] mem [0:1023];
  always @(posedge clk) if (bus.imem_en) bus.imem_dout <= mem[bus.imem_addr[9:0]];

  int vectors = 0;
  int errors  = 0;
  logic [31:0] exp_q[$];
  int idle = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else
      $display("ok   %s: %h", name, act);
  endtask

  task automatic expect_out(input string name, input logic [31:0] p, input logic [63:0] i);
    check({name, ".pc"}, {32'h0, bus.pc}, {32'h0, p});
    check({name, ".inst"}, bus.inst, i);
  endtask

  // Expected consumption order restarts at every redirect / reset target.
  task automatic push_run(input logic [31:0] start);
    exp_q.delete();
    for (int k = 0; k < 512; k++) exp_q.push_back(start + 32'(k));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decode consumes pc/inst in every cycle without interlock or redirect.
  always @(negedge clk) begin
    if (!rstn) begin
      idle = 0;
    end else if (bus.branch_flag) begin
      idle = 0;
    end else if (!bus.interlock) begin
      if (bus.inst !== NOPB) begin
        idle = 0;
        if (exp_q.size() == 0) begin
          check("stream_unexpected", {32'h0, bus.pc}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          logic [31:0] p;
          p = exp_q.pop_front();
          check("stream_pc", {32'h0, bus.pc}, {32'h0, p});
          check("stream_inst", bus.inst, mem[p[9:0]]);
        end
      end else begin
        idle++;
        if (idle > 8) begin
          check("stream_stalled_cycles", 64'(idle), 64'd8);
          idle = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = {$urandom, $urandom};
      while (mem[i] == NOPB) mem[i] = {$urandom, $urandom};
    end
    bus.interlock   = 1'b0;
    bus.branch_flag = 1'b0;
    bus.branch_pc   = 32'h0;
    push_run(32'h0);

    // Reset values and first-fetch latency
    repeat (3) tick();
    expect_out("reset", 32'h0, NOPB);
    check("reset.imem_en", {63'h0, bus.imem_en}, 64'h0);
    rstn = 1'b1;
    tick();
    expect_out("boot_e1", 32'h0, NOPB);
    check("boot_e1.imem_en", {63'h0, bus.imem_en}, 64'h1);
    check("boot_e1.imem_addr", 64'(bus.imem_addr), 64'h0);
    tick();
    expect_out("boot_e2", 32'h0, NOPB);
    tick();
    expect_out("first_A", 32'h0, mem[0]);
    tick();
    expect_out("first_B", 32'h1, mem[1]);

    // Interlock for three cycles while 1/B is presented
    bus.interlock = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_out("hold", 32'h1, mem[1]);
      check("hold.imem_en", {63'h0, bus.imem_en}, 64'h0);
    end
    bus.interlock = 1'b0;
    #1;
    check("hold_release.imem_en", {63'h0, bus.imem_en}, 64'h0);
    tick();
    expect_out("drain_C", 32'h2, mem[2]);

    // Redirect to 0x40 while pc=2
    bus.branch_flag = 1'b1;
    bus.branch_pc   = 32'h40;
    push_run(32'h40);
    tick();
    bus.branch_flag = 1'b0;
    expect_out("br_nop1", 32'h2, NOPB);
    tick();
    expect_out("br_nop2", 32'h2, NOPB);
    tick();
    expect_out("br_tgt", 32'h40, mem[10'h40]);
    tick();
    expect_out("br_tgt1", 32'h41, mem[10'h41]);

    // Redirect together with interlock while in HOLD
    bus.interlock = 1'b1;
    tick();
    tick();
    bus.branch_flag = 1'b1;
    bus.branch_pc   = 32'h80;
    push_run(32'h80);
    tick();
    bus.branch_flag = 1'b0;
    bus.interlock   = 1'b0;
    #1;
    check("hold_br.imem_en", {63'h0, bus.imem_en}, 64'h1);
    expect_out("hold_br_nop1", 32'h41, NOPB);
    tick();
    expect_out("hold_br_nop2", 32'h41, NOPB);
    tick();
    expect_out("hold_br_tgt", 32'h80, mem[10'h80]);

    // Asynchronous reset in the middle of HOLD
    bus.interlock = 1'b1;
    tick();
    tick();
    rstn = 1'b0;
    push_run(32'h0);
    #1;
    expect_out("async_rst", 32'h0, NOPB);
    check("async_rst.imem_en", {63'h0, bus.imem_en}, 64'h0);
    bus.interlock = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k < 3) expect_out("restart_nop", 32'h0, NOPB);
      else       expect_out("restart", 32'(k - 3), mem[k - 3]);
    end

    // Redirect with one bundle in flight, targeting the PC wrap point
    bus.branch_flag = 1'b1;
    bus.branch_pc   = 32'hFFFF_FFFE;
    push_run(32'hFFFF_FFFE);
    tick();
    bus.branch_flag = 1'b0;
`ifdef FETCH_PERF_EN
    check("perf_fetched", {32'h0, perf_fetched}, 64'd10);
    check("perf_squashed", {32'h0, perf_squashed}, 64'd1);
`endif
    expect_out("wrap_nop1", 32'h9, NOPB);
    tick();
    expect_out("wrap_nop2", 32'h9, NOPB);
    tick();
    expect_out("wrap_m2", 32'hFFFF_FFFE, mem[10'h3FE]);
    tick();
    expect_out("wrap_m1", 32'hFFFF_FFFF, mem[10'h3FF]);
    tick();
    expect_out("wrap_0", 32'h0, mem[0]);

    // Random interlock and redirect traffic, scored by the stream monitor
    for (int c = 0; c < 600; c++) begin
      if (bus.branch_flag) begin
        bus.branch_flag = 1'b0;
      end else if ($urandom_range(0, 19) == 0) begin
        logic [31:0] t;
        t = $urandom;
        bus.branch_flag = 1'b1;
        bus.branch_pc   = t;
        push_run(t);
      end
      bus.interlock = ($urandom_range(0, 3) == 0);
      tick();
    end
    bus.branch_flag = 1'b0;
    bus.interlock   = 1'b0;
    repeat (6) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
